// File: rtl/mc_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath/memory port.
// The master side (mc_control) drives the enables and mux selects, and the slave side returns opcode, zero and mem_ready.
interface mc_control_if;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    logic [OP_W-1:0]    opcode;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               pcen;
    logic [1:0]         pcsrc;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [2:0]         aluop;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               aluop, regdst, memtoreg, regwrite, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               aluop, regdst, memtoreg, regwrite, illegal_op, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS sequencer: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
// All outputs are decoded from the state register and are held at zero while rst is high.
module mc_control (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        IEX    = 4'd8,
        IWB    = 4'd9,
        BR     = 4'd10,
        JMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next state and outputs; everything stays zero while rst is asserted.
    always_comb begin
        state_d        = state_q;
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcen       = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.aluop      = 3'b000;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.illegal_op = 1'b0;
        bus.state      = 4'd0;

        if (!rst) begin
            bus.state = state_q;
            case (state_q)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.irwrite = bus.mem_ready;
                    bus.pcen    = bus.mem_ready;
                    if (bus.mem_ready) state_d = DECODE;
                end
                DECODE: begin
                    bus.alusrcb = 2'b11;
                    case (bus.opcode)
                        OP_LW, OP_SW:   state_d = MEMADR;
                        OP_RTYPE:       state_d = REX;
                        OP_ADDI:        state_d = IEX;
                        OP_BEQ, OP_BNE: state_d = BR;
                        OP_J:           state_d = JMP;
                        default: begin
                            state_d        = FETCH;
                            bus.illegal_op = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    if (bus.mem_ready) state_d = MEMWB;
                end
                MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                    state_d      = FETCH;
                end
                MEMWR: begin
                    bus.mem_req  = 1'b1;
                    bus.iord     = 1'b1;
                    bus.memwrite = 1'b1;
                    if (bus.mem_ready) state_d = FETCH;
                end
                REX: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 3'b101;
                    state_d     = RWB;
                end
                RWB: begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 1'b1;
                    state_d      = FETCH;
                end
                IEX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    state_d     = IWB;
                end
                IWB: begin
                    bus.regwrite = 1'b1;
                    state_d      = FETCH;
                end
                BR: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 3'b001;
                    bus.pcsrc   = 2'b01;
                    bus.pcen    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                    state_d     = FETCH;
                end
                JMP: begin
                    bus.pcsrc = 2'b10;
                    bus.pcen  = 1'b1;
                    state_d   = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through its state sequence and checks
// the decoded controls against hand-computed values.
module tb_mc_control;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mc_control_if bus ();

    mc_control u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle. Callers update inputs and then wait #1 before checking.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Every control output packed together, so that one comparison covers all of them.
    function automatic logic [31:0] all_outs();
        return 32'({bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                    bus.alusrca, bus.alusrcb, bus.aluop, bus.regdst, bus.memtoreg,
                    bus.regwrite, bus.illegal_op, bus.state});
    endfunction

    // From a FETCH cycle, count the cycles until the next FETCH (bounded).
    task automatic run_to_fetch(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.state != 4'd0 && n < 40);
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = OP_LW;
        bus.zero = 1'b0;

        // Reset with mem_ready high: every output is zero and there is no irwrite or pcen.
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("reset_outs", all_outs(), 32'd0);
        end
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rel_state", 32'(bus.state), 32'd0);
        check("rel_memreq", 32'(bus.mem_req), 32'd1);
        check("rel_iord", 32'(bus.iord), 32'd0);
        check("rel_irwrite_wait", 32'(bus.irwrite), 32'd0);
        tick();
        #1;
        check("fetch_wait_stay", 32'(bus.state), 32'd0);

        // lw with no wait states: 0,1,2,3,4,0
        bus.mem_ready = 1'b1;
        #1;
        check("lw_fetch_irwrite", 32'(bus.irwrite), 32'd1);
        check("lw_fetch_pcen", 32'(bus.pcen), 32'd1);
        check("lw_fetch_alusrcb", 32'(bus.alusrcb), 32'd1);
        tick(); #1;
        check("lw_decode", 32'(bus.state), 32'd1);
        check("lw_decode_alusrcb", 32'(bus.alusrcb), 32'd3);
        tick(); #1;
        check("lw_memadr", 32'(bus.state), 32'd2);
        check("lw_memadr_ctl", 32'({bus.alusrca, bus.alusrcb, bus.aluop}), 32'b1_10_000);
        bus.opcode = OP_BAD;
        tick(); #1;
        check("lw_memrd", 32'(bus.state), 32'd3);
        check("lw_memrd_req", 32'({bus.mem_req, bus.iord, bus.memwrite}), 32'b110);
        tick(); #1;
        check("lw_memwb", 32'(bus.state), 32'd4);
        check("lw_memwb_ctl", 32'({bus.regwrite, bus.memtoreg, bus.regdst}), 32'b110);
        tick(); #1;
        check("lw_back_fetch", 32'(bus.state), 32'd0);

        // sw with three wait cycles in MEMWR
        bus.opcode = OP_SW;
        tick(); tick(); #1;
        check("sw_memadr", 32'(bus.state), 32'd2);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            check("sw_memwr_state", 32'(bus.state), 32'd5);
            check("sw_memwr_req", 32'({bus.mem_req, bus.memwrite, bus.iord}), 32'b111);
            check("sw_no_regwrite", 32'(bus.regwrite), 32'd0);
            tick();
        end
        #1;
        check("sw_back_fetch", 32'(bus.state), 32'd0);

        // beq taken
        bus.opcode = OP_BEQ;
        bus.zero = 1'b1;
        tick(); tick(); #1;
        check("beq_state", 32'(bus.state), 32'd10);
        check("beq_t_ctl", 32'({bus.pcen, bus.pcsrc, bus.aluop, bus.alusrca}), 32'b1_01_001_1);
        tick(); #1;
        check("beq_back_fetch", 32'(bus.state), 32'd0);
        // beq not taken
        bus.zero = 1'b0;
        tick(); tick(); #1;
        check("beq_nt_pcen", 32'(bus.pcen), 32'd0);
        tick(); #1;
        // bne with zero=0 is taken, with zero=1 not taken; also 3-cycle latency
        bus.opcode = OP_BNE;
        tick(); tick(); #1;
        check("bne_t_pcen", 32'(bus.pcen), 32'd1);
        bus.zero = 1'b1;
        #1;
        check("bne_nt_pcen", 32'(bus.pcen), 32'd0);
        tick(); #1;
        run_to_fetch("bne_latency", 3);

        // R-type followed by addi: 8 cycles in total
        bus.opcode = OP_RTYPE;
        tick(); tick(); #1;
        check("rex_state", 32'(bus.state), 32'd6);
        check("rex_ctl", 32'({bus.alusrca, bus.alusrcb, bus.aluop}), 32'b1_00_101);
        tick(); #1;
        check("rwb_ctl", 32'({bus.state, bus.regwrite, bus.regdst}), 32'b0111_1_1);
        tick();
        bus.opcode = OP_ADDI;
        tick(); tick(); #1;
        check("iex_ctl", 32'({bus.state, bus.alusrca, bus.alusrcb, bus.aluop}), 32'b1000_1_10_000);
        tick(); #1;
        check("iwb_ctl", 32'({bus.state, bus.regwrite, bus.regdst}), 32'b1001_1_0);
        tick(); #1;
        check("addi_back_fetch", 32'(bus.state), 32'd0);
        bus.opcode = OP_ADDI;
        run_to_fetch("addi_latency", 4);

        // jump
        bus.opcode = OP_J;
        tick(); tick(); #1;
        check("jmp_ctl", 32'({bus.state, bus.pcen, bus.pcsrc}), 32'b1011_1_10);
        tick(); #1;
        bus.opcode = OP_J;
        run_to_fetch("j_latency", 3);

        // illegal opcode: single-cycle pulse in DECODE
        bus.opcode = OP_BAD;
        tick(); #1;
        check("ill_decode", 32'({bus.state, bus.illegal_op}), 32'b0001_1);
        tick(); #1;
        check("ill_fetch", 32'({bus.state, bus.illegal_op}), 32'b0000_0);
        run_to_fetch("ill_latency", 2);

        // lw latency with one wait cycle in MEMRD
        bus.opcode = OP_LW;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); #1;
        check("memrd_wait", 32'(bus.state), 32'd3);

        // Reset during a MEMRD wait abandons the request
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_mid_outs", all_outs(), 32'd0);
        tick(); #1;
        check("rst_mid_outs2", all_outs(), 32'd0);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_mid_state", 32'({bus.state, bus.mem_req, bus.iord, bus.regwrite}), 32'b0000_1_0_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle sequencing controller for the shared-memory MIPS datapath. It replaces per-instruction combinational decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the single-port memory handshake, the instruction-register load, the PC enable, the register-file write and all datapath muxes. It sits between the instruction register's opcode field and the datapath/memory-interface enables.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction-register bits [31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completion; ignored while mem_req=0.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  out  1  write strobe, qualified by mem_req.
- irwrite  out  1  instruction-register load enable.
- pcen  out  1  PC load enable.
- pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alusrca  out  1  ALU A: 0=PC, 1=rs register.
- alusrcb  out  2  ALU B: 00=rt register, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- aluop  out  3  000=add, 001=sub, 101=decode from funct.
- regdst  out  1  destination register: 0=rt, 1=rd.
- memtoreg  out  1  write-back data: 0=ALUOut, 1=memory data register.
- regwrite  out  1  register-file write enable.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- Supported opcodes: 100011 lw, 101011 sw, 000000 R-type, 001000 addi, 000100 beq, 000101 bne, 000010 j.
- Moore outputs are decoded from the state register. Every output is 0 unless listed for the current state.
- Exceptions to Moore: irwrite and pcen in FETCH follow mem_ready; pcen in BRANCH follows zero.
- State encodings, outputs and transitions:
  - FETCH=0: mem_req, alusrcb=01, aluop=000, pcsrc=00. irwrite=pcen=mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE=1: alusrcb=11, aluop=000 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR.
    - R-type → REX.
    - addi → IEX.
    - beq/bne → BR.
    - j → JMP.
    - any other opcode → FETCH, with illegal_op=1 this cycle.
  - MEMADR=2: alusrca, alusrcb=10, aluop=000. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD=3: mem_req, iord. Go to MEMWB on mem_ready, else stay.
  - MEMWB=4: regwrite, memtoreg, regdst=0. Go to FETCH.
  - MEMWR=5: mem_req, iord, memwrite. Go to FETCH on mem_ready, else stay.
  - REX=6: alusrca, alusrcb=00, aluop=101. Go to RWB.
  - RWB=7: regwrite, regdst=1. Go to FETCH.
  - IEX=8: alusrca, alusrcb=10, aluop=000. Go to IWB.
  - IWB=9: regwrite, regdst=0. Go to FETCH.
  - BR=10: alusrca, alusrcb=00, aluop=001, pcsrc=01. pcen=zero for beq, pcen=~zero for bne. Go to FETCH.
  - JMP=11: pcsrc=10, pcen. Go to FETCH.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Handshake: once mem_req rises, mem_req, iord and memwrite hold constant until the cycle in which mem_ready=1. The transfer completes in that cycle, and mem_req drops on the next cycle unless the new state also requests.
- opcode is sampled only in DECODE, BR and MEMADR. Changes at other times have no effect.

## Timing
- Reset: while rst=1 at a rising edge, state becomes FETCH.
- While rst is high, all outputs are forced to 0, including mem_req, pcen, regwrite and memwrite. The first FETCH request is issued in the cycle after rst deasserts.
- Reset mid-operation: an outstanding request is abandoned, no writes occur, and mem_ready is ignored during reset.
- Latency with zero wait states (mem_ready=1 in the first request cycle), in cycles:
  - lw=5.
  - sw=4.
  - R-type=4.
  - addi=4.
  - beq/bne=3.
  - j=3.
  - illegal=2.
- Each wait cycle on a memory access adds exactly 1 cycle.
- A branch or jump takes effect on the PC at the edge that leaves BR/JMP. The next FETCH uses the new PC.
- Simultaneous rst=1 and mem_ready=1: reset wins, and no irwrite or pcen pulse is issued.

## Test plan
- Reset: hold rst 3 cycles with mem_ready=1 → all outputs 0 and state=0. Release → state=0 with mem_req=1, iord=0 in the next cycle.
- lw, zero wait: state sequence 0,1,2,3,4,0. irwrite=pcen=1 in FETCH; iord=1 in MEMRD; regwrite=memtoreg=1, regdst=0 in MEMWB.
- sw with mem_ready held low 3 cycles in MEMWR → mem_req=memwrite=iord stable for 4 cycles, then FETCH. regwrite never asserts.
- beq with zero=1 → pcen=1, pcsrc=01 in BR. beq with zero=0 → pcen=0. bne with zero=0 → pcen=1.
- R-type then addi back-to-back → aluop=101, regdst=1 in REX/RWB; aluop=000, alusrcb=10, regdst=0 in IEX/IWB. Total 8 cycles.
- Opcode 111111 → illegal_op=1 for exactly one cycle in DECODE, then FETCH. Assert rst during MEMRD wait → mem_req=0 immediately, state=0.
